// File: rtl/filt_cicd_pkg.sv
// Shared helpers and types for the multi-channel CIC decimator.
package filt_cicd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    // Ceiling log2, usable in parameter and port width expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Bit growth of an N-stage CIC with ratio R and delay D on top of the input width.
    function automatic int full_width(input int inp_width, input int order,
                                      input int dec_max, input int diff_delay);
        return inp_width + order * clog2(dec_max * diff_delay);
    endfunction

    // A ratio of 0 means 1; anything above the supported maximum saturates.
    function automatic int clamp_rate(input int rate, input int rate_max);
        if (rate < 1) return 1;
        if (rate > rate_max) return rate_max;
        return rate;
    endfunction

endpackage

// File: rtl/filt_cicd_integ.sv
// One channel's N-stage integrator cascade. The cascade is evaluated within the
// cycle, so the stage-N sum already includes the sample presented this cycle.
module filt_cicd_integ #(
    parameter int gp_order      = 3,
    parameter int gp_inp_width  = 8,
    parameter int gp_full_width = 20
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic signed [gp_inp_width-1:0]  din,
    output logic        [gp_full_width-1:0] sum
);
    localparam int FW = gp_full_width;
    localparam int IW = gp_inp_width;

    logic [gp_order-1:0][FW-1:0] acc;
    logic [gp_order:0][FW-1:0]   nxt;

    // Next value of every stage; stage 0 is the sign-extended sample, wrap is intended.
    always_comb begin
        nxt[0] = {{(FW-IW){din[IW-1]}}, din};
        for (int k = 1; k <= gp_order; k++) nxt[k] = acc[k-1] + nxt[k-1];
    end

    assign sum = nxt[gp_order];

    // Integrator state advances only on an enabled input sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            for (int k = 0; k < gp_order; k++) acc[k] <= nxt[k+1];
        end
    end

endmodule

// File: rtl/filt_cicd_mc.sv
// Multi-channel CIC decimator: per-channel integrators, one shared comb that
// walks the channels serially after each decimation boundary.
module filt_cicd_mc
    import filt_cicd_pkg::*;
#(
    parameter int gp_channels       = 2,
    parameter int gp_decimation_max = 16,
    parameter int gp_order          = 3,
    parameter int gp_diff_delay     = 1,
    parameter int gp_inp_width      = 8,
    parameter int gp_full_width     = full_width(gp_inp_width, gp_order, gp_decimation_max, gp_diff_delay),
    parameter int gp_oup_width      = gp_full_width
) (
    input  logic                                                 i_clk,
    input  logic                                                 i_rst_an,
    input  logic                                                 i_ena,
    input  logic [clog2(gp_decimation_max+1)-1:0]                i_rate,
    input  logic                                                 i_valid,
    input  logic [gp_channels*gp_inp_width-1:0]                  i_data,
    output logic                                                 o_valid,
    output logic [((gp_channels > 1) ? clog2(gp_channels) : 1)-1:0] o_chan,
    output logic signed [gp_oup_width-1:0]                       o_data,
    output logic                                                 o_overrun
);
    localparam int RW = clog2(gp_decimation_max + 1);
    localparam int CW = (gp_channels > 1) ? clog2(gp_channels) : 1;
    localparam int FW = gp_full_width;
    localparam int IW = gp_inp_width;
    localparam int N  = gp_order;
    localparam int D  = gp_diff_delay;

    logic                             step;
    logic [gp_channels-1:0][FW-1:0]   integ_sum;
    logic [gp_channels-1:0][FW-1:0]   snap;
    logic [gp_channels-1:0][N-1:0][D-1:0][FW-1:0] dly;
    logic [N:0][FW-1:0]               c_chain;
    logic [RW-1:0]                    count, r_eff, r_cur, rate_clamped;
    logic                             boundary, last, accept, drop;
    fsm_state_t                       state, state_nxt;
    logic [CW-1:0]                    p, p_nxt;
    logic                             valid_q;
    logic [FW-1:0]                    res;

    assign step = i_ena & i_valid;

    genvar c;
    generate
        for (c = 0; c < gp_channels; c++) begin : g_ch
            filt_cicd_integ #(
                .gp_order      (N),
                .gp_inp_width  (IW),
                .gp_full_width (FW)
            ) u_integ (
                .clk   (i_clk),
                .rst_n (i_rst_an),
                .en    (step),
                .din   (i_data[c*IW +: IW]),
                .sum   (integ_sum[c])
            );
        end
    endgenerate

    // r_eff == 0 only right after reset: the live (clamped) request stands in until loaded.
    assign rate_clamped = RW'(clamp_rate(int'(i_rate), gp_decimation_max));
    assign r_cur        = (r_eff == '0) ? rate_clamped : r_eff;
    assign boundary     = step && (count == r_cur - 1'b1);
    assign last         = (p == CW'(gp_channels - 1));
    assign accept       = boundary && ((state == IDLE) || last);
    assign drop         = boundary && (state == RUN) && !last;

    // Decimation counter; the ratio is only re-sampled at a frame boundary.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            count <= '0;
            r_eff <= '0;
        end else if (i_ena) begin
            if (boundary || r_eff == '0) r_eff <= rate_clamped;
            if (step) count <= boundary ? '0 : count + 1'b1;
        end
    end

    // Channel sequencer: one comb evaluation per RUN cycle, back-to-back frames allowed on the last one.
    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    p_nxt     = '0;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = accept ? RUN : IDLE;
                    p_nxt     = '0;
                end else begin
                    p_nxt = p + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                p_nxt     = '0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state <= IDLE;
            p     <= '0;
        end else if (i_ena) begin
            state <= state_nxt;
            p     <= p_nxt;
        end
    end

    // Capture all channels' integrator outputs when a boundary is accepted.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) snap <= '0;
        else if (i_ena && accept) snap <= integ_sum;
    end

    // Shared comb chain for the channel currently selected by p.
    always_comb begin
        c_chain[0] = snap[p];
        for (int k = 0; k < N; k++) c_chain[k+1] = c_chain[k] - dly[p][k][D-1];
    end

    // Differential delay lines; only the channel being combed shifts.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            dly <= '0;
        end else if (i_ena && state == RUN) begin
            for (int k = 0; k < N; k++) begin
                for (int j = D - 1; j > 0; j--) dly[p][k][j] <= dly[p][k][j-1];
                dly[p][k][0] <= c_chain[k];
            end
        end
    end

    // Output register: result becomes visible the cycle after its comb pass.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            valid_q <= 1'b0;
            o_chan  <= '0;
            res     <= '0;
        end else if (i_ena) begin
            valid_q <= (state == RUN);
            if (state == RUN) begin
                o_chan <= p;
                res    <= c_chain[N];
            end
        end
    end

    // Sticky flag for a boundary that arrived while the comb was still busy.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) o_overrun <= 1'b0;
        else if (i_ena && drop) o_overrun <= 1'b1;
    end

    assign o_valid = valid_q & i_ena;
    assign o_data  = res[FW-1 -: gp_oup_width];

endmodule

// File: tb/tb_filt_cicd_mc.sv
// Bench for filt_cicd_mc: a 2-channel instance for the main function and a
// 4-channel instance for the overrun case, both checked against a model that
// applies the binomial comb formula to the N-fold running sums of the input.
module tb_filt_cicd_mc;
    localparam int N  = 3;
    localparam int D  = 1;
    localparam int IW = 8;
    localparam int FW = 20;
    localparam int RMAX = 16;

    logic        clk = 1'b0;
    logic        rst1, rst2, ena, vld;
    logic [4:0]  rate;
    logic [31:0] data4;

    logic              v1, ov1, v2, ov2;
    logic [0:0]        ch1;
    logic [1:0]        ch2;
    logic signed [FW-1:0] d1, d2;

    always #5 clk = ~clk;

    filt_cicd_mc u_dut2ch (
        .i_clk(clk), .i_rst_an(rst1), .i_ena(ena), .i_rate(rate), .i_valid(vld),
        .i_data(data4[15:0]), .o_valid(v1), .o_chan(ch1), .o_data(d1), .o_overrun(ov1)
    );

    filt_cicd_mc #(.gp_channels(4)) u_dut4ch (
        .i_clk(clk), .i_rst_an(rst2), .i_ena(ena), .i_rate(rate), .i_valid(vld),
        .i_data(data4), .o_valid(v2), .o_chan(ch2), .o_data(d2), .o_overrun(ov2)
    );

    typedef struct {
        longint k;
        int     ch;
        longint data;
    } ev_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    bit     sel;
    int     nch;
    longint kcnt;
    int     fill, r_m;
    bit     have_acc, exp_ovr;
    longint last_acc;
    longint cs[4][N];
    longint hs[4][N*D+1];
    longint last_out[4];
    ev_t    evq[$];

    function automatic longint wrapf(input longint v);
        longint m;
        m = v & ((64'sd1 <<< FW) - 1);
        if (m[FW-1]) m = m - (64'sd1 <<< FW);
        return m;
    endfunction

    function automatic longint binom(input int n, input int k);
        longint r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    function automatic int clampf(input int r);
        return (r < 1) ? 1 : ((r > RMAX) ? RMAX : r);
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        kcnt = 0; fill = 0; r_m = clampf(int'(rate));
        have_acc = 0; exp_ovr = 0; last_acc = 0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < N; k++) cs[c][k] = 0;
            for (int j = 0; j <= N*D; j++) hs[c][j] = 0;
            last_out[c] = 0;
        end
        evq.delete();
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, then advance the model.
    task automatic step(input bit e, input bit v, input logic [31:0] dat);
        logic signed [63:0] obs_v, obs_o, obs_d;
        int     obs_c;
        bit     due;
        longint y;
        ena = e; vld = v; data4 = dat;
        @(negedge clk);
        obs_v = sel ? v2 : v1;
        obs_o = sel ? ov2 : ov1;
        obs_d = sel ? d2 : d1;
        obs_c = sel ? int'(ch2) : int'(ch1);
        due = e && (evq.size() > 0) && (evq[0].k == kcnt);
        chk("o_valid", obs_v, due);
        if (due) begin
            chk("o_chan", obs_c, evq[0].ch);
            chk("o_data", obs_d, evq[0].data);
            void'(evq.pop_front());
        end
        if (obs_v === 64'sd1) last_out[obs_c] = obs_d;
        chk("o_overrun", obs_o, exp_ovr);
        if (e) begin
            if (v) begin
                for (int c = 0; c < nch; c++) begin
                    cs[c][0] = wrapf(cs[c][0] + longint'(signed'(dat[c*IW +: IW])));
                    for (int k = 1; k < N; k++) cs[c][k] = wrapf(cs[c][k] + cs[c][k-1]);
                end
                fill++;
                if (fill >= r_m) begin
                    fill = 0;
                    r_m  = clampf(int'(rate));
                    if (!have_acc || kcnt >= last_acc + nch) begin
                        have_acc = 1;
                        last_acc = kcnt;
                        for (int c = 0; c < nch; c++) begin
                            for (int j = N*D; j > 0; j--) hs[c][j] = hs[c][j-1];
                            hs[c][0] = cs[c][N-1];
                            y = 0;
                            for (int j = 0; j <= N; j++)
                                y += ((j % 2 == 1) ? -binom(N, j) : binom(N, j)) * hs[c][j*D];
                            evq.push_back('{k: kcnt + 2 + c, ch: c, data: wrapf(y)});
                        end
                    end else begin
                        exp_ovr = 1;
                    end
                end
            end
            kcnt++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        rst1 = 0; rst2 = 0; ena = 0; vld = 0; rate = 5'd4; data4 = '0;
        sel = 0; nch = 2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", v1, 0);
        chk("rst_chan", ch1, 0);
        chk("rst_data", d1, 0);
        chk("rst_overrun", ov1, 0);
        rst1 = 1;
        model_reset();

        // DC: ch0 = +1, ch1 = -1, R = 4
        for (int i = 0; i < 40; i++) step(1, 1, {16'h0, 8'hFF, 8'h01});
        chk("dc_plus1", last_out[0], 64);
        chk("dc_minus1", last_out[1], -64);

        // Full-scale negative input exercises the wrap arithmetic
        for (int i = 0; i < 40; i++) step(1, 1, {16'h0, 8'($urandom()), 8'h80});
        chk("dc_m128", last_out[0], -8192);

        // Ratio 4 -> 2 requested mid-frame
        for (int i = 0; i < 2; i++) step(1, 1, {16'h0, 8'($urandom()), 8'h01});
        rate = 5'd2;
        for (int i = 0; i < 40; i++) step(1, 1, {16'h0, 8'($urandom()), 8'h01});
        chk("rate2_dc", last_out[0], 8);

        // Ratio 0 clamps to 1; samples every other cycle keep the comb free
        rate = 5'd0;
        for (int i = 0; i < 40; i++) begin
            step(1, 1, {16'h0, 8'($urandom()), 8'h01});
            step(1, 0, {16'h0, 8'($urandom()), 8'h01});
        end
        chk("rate0_gain1", last_out[0], 1);

        // Ratio 31 clamps to 16
        rate = 5'd31;
        for (int i = 0; i < 100; i++) step(1, 1, {16'h0, 8'($urandom()), 8'h01});
        chk("rate31_gain", last_out[0], 4096);

        // Random data, random strobes, random ratio requests, with an enable gap
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) == 0) rate = 5'($urandom_range(2, 20));
            if (i >= 60 && i < 65) step(0, 1, $urandom());
            else step(1, ($urandom_range(0, 3) != 0), $urandom());
        end

        // Reset while an output is on the bus
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (evq.size() > 0 && evq[0].k == kcnt) found = 1;
            else step(1, 1, $urandom());
        end
        chk("rst_run_reached", found, 1);
        ena = 1; vld = 0;
        #1;
        chk("pre_rst_valid", v1, 1);
        rst1 = 0;
        #1;
        chk("midrst_valid", v1, 0);
        chk("midrst_data", d1, 0);
        chk("midrst_chan", ch1, 0);
        @(posedge clk); #1;
        rst1 = 1;
        model_reset();
        chk("post_rst_valid", v1, 0);
        chk("post_rst_data", d1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, $urandom());
        for (int i = 0; i < 40; i++) step(1, ($urandom_range(0, 3) != 0), $urandom());

        // Overrun: 4 channels, R = 1, a sample every cycle
        rate = 5'd1;
        chk("rst4_valid", v2, 0);
        chk("rst4_overrun", ov2, 0);
        sel = 1; nch = 4;
        rst2 = 1;
        model_reset();
        for (int i = 0; i < 30; i++) step(1, 1, $urandom());
        chk("overrun_sticky", ov2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/filt_cicd_mc.md
Name: filt_cicd_mc

Overview:
- Multi-channel CIC decimator with a decimation ratio that can be changed at run time. It is the parametrised successor of the single-channel filt_cicd.
- Each channel has its own integrator cascade. One comb section is shared and time-multiplexed across channels.
- The derived slow clock is replaced by a single-clock valid-strobe interface: output is serial, one channel per cycle, tagged with a channel index.
- Sits between the modulator/front-end sample stream and downstream FIR compensation filters.

Parameters:
- gp_channels, 2, number of parallel input channels (≥1).
- gp_decimation_max, 16, largest supported decimation ratio R; sets register widths.
- gp_order, 3, number of integrator and comb stages N.
- gp_diff_delay, 1, comb differential delay D (1 or 2).
- gp_inp_width, 8, signed input sample width.
- gp_full_width, gp_inp_width+gp_order*clog2(gp_decimation_max*gp_diff_delay), internal precision; derived, do not override.
- gp_oup_width, gp_full_width, output width (≤ gp_full_width); MSBs of the full-precision result are kept.

Ports:
- i_clk  in  1  system clock.
- i_rst_an  in  1  asynchronous active-low reset.
- i_ena  in  1  global enable; low freezes all state.
- i_rate  in  clog2(gp_decimation_max+1)  requested decimation ratio R.
- i_valid  in  1  input frame strobe; one sample per channel.
- i_data  in  gp_channels*gp_inp_width  signed samples; channel c occupies bits [c*W +: W].
- o_valid  out  1  one-cycle output strobe.
- o_chan  out  clog2(gp_channels) (min 1)  channel index of o_data.
- o_data  out  gp_oup_width  signed decimated sample.
- o_overrun  out  1  sticky: a decimation boundary arrived while the comb was busy.

Behaviour:
- Reset (async, i_rst_an=0): integrators, comb delay lines, snapshot registers and the decimation counter clear to 0. FSM goes to IDLE. Effective rate register loads clamp(i_rate) on deassertion. o_valid=0, o_chan=0, o_data=0, o_overrun=0.
- i_ena=0: no register changes; o_valid is forced to 0. Counter, FSM position and pending work resume unchanged when i_ena returns.
- Integrators: on i_valid&i_ena, each channel runs I_k += I_(k-1) with I_0 = sign-extended i_data.
  - Arithmetic is gp_full_width two's complement with intentional wrap; no saturation.
- Decimation counter:
  - Increments on i_valid&i_ena.
  - On the i_valid where count == R_eff-1 (the boundary cycle t) it wraps to 0, asserts snapshot, and loads R_eff = clamp(i_rate).
  - clamp: 0 becomes 1; values above gp_decimation_max become gp_decimation_max.
  - A rate change therefore takes effect only at a boundary, never mid-frame.
- Snapshot: at the end of cycle t, the stage-N integrator outputs of all channels, including the cycle-t sample, are captured.
- FSM states IDLE and RUN.
  - IDLE goes to RUN on snapshot, with channel pointer p=0.
  - In RUN, cycle t+1+p: channel p's snapshot passes through N comb stages in one combinational chain, C_k = C_(k-1) − z^-D C_(k-1), using per-channel, per-stage D-deep delay registers. Delay registers update for channel p only.
  - The result goes to the output register. o_valid=1, o_chan=p and o_data=result[gp_full_width-1 -: gp_oup_width] are all visible in cycle t+2+p.
  - p increments each cycle. After p = gp_channels-1, return to IDLE.
- Latency: 2 cycles from the boundary i_valid to channel 0 output. Channel c output follows at boundary + 2 + c.
- Overrun: a snapshot request while in RUN, other than in the last RUN cycle, is dropped. Integrators still advance, o_overrun sets and stays set until reset.
  - Requirement on users: R × i_valid spacing ≥ gp_channels.
- Reset asserted mid-RUN: the sequence aborts immediately and no further o_valid is produced.
- DC gain is (R·D)^N, unnormalised.

Decomposition:
- Package filt_cicd_pkg holds:
  - clog2 and full-width functions;
  - fsm state enum (IDLE, RUN);
  - the clamp function for the rate.
- Sub-module filt_cicd_integ: one channel's N-stage integrator cascade with enable, generated gp_channels times.
- Comb, counter and FSM stay in the top level.

Test Plan:
- Defaults, R=4, i_valid every cycle. ch0 held at +1, ch1 held at −1. After 3 outputs per channel, ch0 = +64 and ch1 = −64. o_chan alternates 0,1. o_valid pairs occur every 4 cycles, 2 cycles after each boundary.
- R=4, ch0=−128 constant: settles to −8192 with no wrap error, i.e. full-width wrap arithmetic is correct.
- Rate change: i_rate 4→2 driven mid-frame. The current frame completes at 4 samples; the next frames use 2. Output settles to DC 8 for input +1.
- Clamp: i_rate=0 behaves as R=1 (output equals input once settled, gain 1). i_rate=31 behaves as R=16 (gain 4096 for input +1).
- Overrun: gp_channels=4, R=1, i_valid every cycle. o_overrun rises at the second boundary, during RUN, and stays 1. Already-started outputs are not corrupted.
- Reset and enable:
  - i_rst_an pulsed low during RUN: o_valid drops in the same cycle, and all outputs read 0 after release.
  - i_ena low for 5 cycles mid-frame: the output sequence is identical to an un-gated run, shifted by 5 cycles.
